// File: rtl/vcve2_vrf_seq_if.sv
// rtl/vcve2_vrf_seq_if.sv - VRF SRAM port and VALU operand handshake between sequencer and datapath
interface vcve2_vrf_seq_if #(
    parameter int VLEN   = 128,
    parameter int WORD_W = 32
);
    localparam int W  = VLEN / WORD_W;
    localparam int AW = 5 + $clog2(W);

    logic              vrf_req_o;
    logic              vrf_we_o;
    logic [AW-1:0]     vrf_addr_o;
    logic [WORD_W-1:0] vrf_wdata_o;
    logic [WORD_W-1:0] vrf_rdata_i;
    logic              valu_valid_o;
    logic              valu_ready_i;
    logic [WORD_W-1:0] op_a_o;
    logic [WORD_W-1:0] op_b_o;
    logic [WORD_W-1:0] op_c_o;
    logic [WORD_W-1:0] valu_result_i;

    modport master (
        output vrf_req_o, vrf_we_o, vrf_addr_o, vrf_wdata_o,
        output valu_valid_o, op_a_o, op_b_o, op_c_o,
        input  vrf_rdata_i, valu_ready_i, valu_result_i
    );

    modport slave (
        input  vrf_req_o, vrf_we_o, vrf_addr_o, vrf_wdata_o,
        input  valu_valid_o, op_a_o, op_b_o, op_c_o,
        output vrf_rdata_i, valu_ready_i, valu_result_i
    );
endinterface

// File: rtl/vcve2_vrf_seq.sv
// rtl/vcve2_vrf_seq.sv - VRF access sequencer stepping each word of an LMUL register group through the VALU
module vcve2_vrf_seq #(
    parameter int VLEN   = 128,
    parameter int WORD_W = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [4:0]      vs1_i,
    input  logic [4:0]      vs2_i,
    input  logic [4:0]      vd_i,
    input  logic [1:0]      num_reads_i,
    input  logic [2:0]      vlmul_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    vcve2_vrf_seq_if.master vrf
);
    localparam int W  = VLEN / WORD_W;
    localparam int WB = $clog2(W);
    localparam int AW = 5 + WB;
    localparam int CW = WB + 3;

    // vlmul_e: fractional settings first, encoding 7 is reserved
    localparam logic [2:0] LMUL_F8   = 3'd0;
    localparam logic [2:0] LMUL_F4   = 3'd1;
    localparam logic [2:0] LMUL_F2   = 3'd2;
    localparam logic [2:0] LMUL_1    = 3'd3;
    localparam logic [2:0] LMUL_2    = 3'd4;
    localparam logic [2:0] LMUL_4    = 3'd5;
    localparam logic [2:0] LMUL_8    = 3'd6;
    localparam logic [2:0] LMUL_RSVD = 3'd7;

    localparam int NF8 = (W >= 8) ? W / 8 : 1;
    localparam int NF4 = (W >= 4) ? W / 4 : 1;
    localparam int NF2 = W / 2;

    typedef enum logic [2:0] {
        VRF_IDLE, VRF_READ1, VRF_READ2, VRF_READ3, V_OP, VRF_WRITE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, n_last_q, n_last_d;
    logic [1:0]        nr_q;
    logic [4:0]        vs1_q, vs2_q, vd_q;
    logic [WORD_W-1:0] op_a_q, op_b_q, op_c_q, wdata_q;
    logic              armed_q, done_q, err_q;
    logic [4:0]        align_mask, reg_sel;
    logic              launch_bad, req, we;
    logic [AW-1:0]     addr;

    always_comb begin
        n_last_d   = '0;
        align_mask = '0;
        case (vlmul_i)
            LMUL_F8: n_last_d = CW'(NF8 - 1);
            LMUL_F4: n_last_d = CW'(NF4 - 1);
            LMUL_F2: n_last_d = CW'(NF2 - 1);
            LMUL_1:  n_last_d = CW'(W - 1);
            LMUL_2:  begin n_last_d = CW'(2 * W - 1); align_mask = 5'b00001; end
            LMUL_4:  begin n_last_d = CW'(4 * W - 1); align_mask = 5'b00011; end
            LMUL_8:  begin n_last_d = CW'(8 * W - 1); align_mask = 5'b00111; end
            default: ;
        endcase
        launch_bad = (vlmul_i == LMUL_RSVD) || (num_reads_i == 2'd0)
                  || (|(vd_i & align_mask)) || (|(vs2_i & align_mask))
                  || (num_reads_i[1] && (|(vs1_i & align_mask)));
    end

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        we      = 1'b0;
        reg_sel = 5'd0;
        case (state_q)
            VRF_IDLE:  if (start_i && !launch_bad) state_d = VRF_READ1;
            VRF_READ1: begin
                req     = 1'b1;
                reg_sel = vs2_q;
                state_d = nr_q[1] ? VRF_READ2 : V_OP;
            end
            VRF_READ2: begin
                req     = 1'b1;
                reg_sel = vs1_q;
                state_d = (nr_q == 2'd3) ? VRF_READ3 : V_OP;
            end
            VRF_READ3: begin
                req     = 1'b1;
                reg_sel = vd_q;
                state_d = V_OP;
            end
            V_OP:      if (armed_q && vrf.valu_ready_i) state_d = VRF_WRITE;
            VRF_WRITE: begin
                req     = 1'b1;
                we      = 1'b1;
                reg_sel = vd_q;
                state_d = (cnt_q == n_last_q) ? VRF_IDLE : VRF_READ1;
            end
            default:   state_d = VRF_IDLE;
        endcase
        // flush only matters once an instruction owns the VRF; start wins in IDLE
        if (flush_i && state_q != VRF_IDLE) begin
            state_d = VRF_IDLE;
            req     = 1'b0;
            we      = 1'b0;
        end
    end

    assign addr             = {reg_sel, {WB{1'b0}}} + AW'(cnt_q);
    assign vrf.vrf_req_o    = req;
    assign vrf.vrf_we_o     = we;
    assign vrf.vrf_addr_o   = req ? addr : '0;
    assign vrf.vrf_wdata_o  = wdata_q;
    assign vrf.valu_valid_o = (state_q == V_OP) && armed_q && !flush_i;
    assign vrf.op_a_o       = op_a_q;
    assign vrf.op_b_o       = op_b_q;
    assign vrf.op_c_o       = op_c_q;
    assign busy_o           = (state_q != VRF_IDLE);
    assign done_o           = done_q;
    assign err_o            = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= VRF_IDLE;
            cnt_q    <= '0;
            n_last_q <= '0;
            nr_q     <= '0;
            vs1_q    <= '0;
            vs2_q    <= '0;
            vd_q     <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_c_q   <= '0;
            wdata_q  <= '0;
            armed_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (flush_i && state_q != VRF_IDLE) begin
                cnt_q   <= '0;
                armed_q <= 1'b0;
            end else begin
                case (state_q)
                    VRF_IDLE: if (start_i) begin
                        if (launch_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            vs1_q    <= vs1_i;
                            vs2_q    <= vs2_i;
                            vd_q     <= vd_i;
                            nr_q     <= num_reads_i;
                            n_last_q <= n_last_d;
                            cnt_q    <= '0;
                            armed_q  <= 1'b0;
                        end
                    end
                    VRF_READ2: op_a_q <= vrf.vrf_rdata_i;
                    VRF_READ3: op_b_q <= vrf.vrf_rdata_i;
                    // first V_OP cycle lands the final read; the VALU sees operands from the next cycle
                    V_OP: if (!armed_q) begin
                        case (nr_q)
                            2'd1:    op_a_q <= vrf.vrf_rdata_i;
                            2'd2:    op_b_q <= vrf.vrf_rdata_i;
                            default: op_c_q <= vrf.vrf_rdata_i;
                        endcase
                        armed_q <= 1'b1;
                    end else if (vrf.valu_ready_i) begin
                        wdata_q <= vrf.valu_result_i;
                        armed_q <= 1'b0;
                    end
                    VRF_WRITE: begin
                        if (cnt_q == n_last_q) done_q <= 1'b1;
                        else                   cnt_q  <= cnt_q + CW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vcve2_vrf_seq.sv
// tb/tb_vcve2_vrf_seq.sv - directed bench for vcve2_vrf_seq against a word-level sequencing model
module tb_vcve2_vrf_seq;
    localparam int W     = 4;
    localparam int DEPTH = 128;

    typedef struct {
        logic        we;
        int          addr;
        logic [31:0] data;
    } acc_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] vs1 = '0, vs2 = '0, vd = '0;
    logic [1:0] nr = '0;
    logic [2:0] lmul = '0;
    logic       flush = 1'b0;
    logic       busy, done, err;
    logic       mem_init = 1'b0;
    logic       stall_on = 1'b0;
    logic       chk_en = 1'b0;
    logic [1:0] stall_cnt = '0;
    int         hs_seen = 0;
    int         vectors = 0;
    int         errors = 0;
    int         base = 0;
    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] mdl_a = '0, mdl_b = '0, mdl_c = '0;
    acc_t        exp_acc [$];
    logic [95:0] exp_ops [$];
    int          seen_addr [$];
    logic        stalled = 1'b0;
    logic [95:0] held_ops = '0;

    vcve2_vrf_seq_if #(.VLEN(128), .WORD_W(32)) bus ();

    vcve2_vrf_seq #(.VLEN(128), .WORD_W(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .vs1_i       (vs1),
        .vs2_i       (vs2),
        .vd_i        (vd),
        .num_reads_i (nr),
        .vlmul_i     (lmul),
        .flush_i     (flush),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .vrf         (bus)
    );

    always #5 clk = ~clk;

    // single-port SRAM with registered read data
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= i * 32'h0001_0001;
        end else if (bus.vrf_req_o) begin
            if (bus.vrf_we_o) mem[bus.vrf_addr_o] <= bus.vrf_wdata_o;
            else              bus.vrf_rdata_i     <= mem[bus.vrf_addr_o];
        end
    end

    assign bus.valu_result_i = bus.op_a_o + bus.op_b_o + bus.op_c_o;
    assign bus.valu_ready_i  = (stall_cnt == 2'd0);

    // VALU back-pressure: three refused cycles on the second word when stall_on
    always @(posedge clk) begin
        if (!busy) begin
            hs_seen <= 0;
        end else if (bus.valu_valid_o && bus.valu_ready_i) begin
            if (stall_on && hs_seen == 0) stall_cnt <= 2'd3;
            hs_seen <= hs_seen + 1;
        end else if (bus.valu_valid_o && stall_cnt != 2'd0) begin
            stall_cnt <= stall_cnt - 2'd1;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        acc_t        e;
        logic [95:0] o;
        if (chk_en && rst_n) begin
            if (stalled) begin
                chk("stall_valid_held", bus.valu_valid_o, 1);
                chk("stall_ops_held", {bus.op_a_o, bus.op_b_o, bus.op_c_o}, held_ops);
            end
            if (bus.vrf_req_o) begin
                seen_addr.push_back(int'(bus.vrf_addr_o));
                if (exp_acc.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_access: got we=%0b addr=%0d expected no access",
                             bus.vrf_we_o, bus.vrf_addr_o);
                end else begin
                    e = exp_acc.pop_front();
                    chk("acc_we", bus.vrf_we_o, e.we);
                    chk("acc_addr", bus.vrf_addr_o, e.addr);
                    if (e.we) chk("acc_wdata", bus.vrf_wdata_o, e.data);
                end
            end
            if (bus.valu_valid_o && bus.valu_ready_i) begin
                if (exp_ops.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_valu: got handshake expected none");
                end else begin
                    o = exp_ops.pop_front();
                    chk("valu_ops", {bus.op_a_o, bus.op_b_o, bus.op_c_o}, o);
                end
            end
            stalled  <= bus.valu_valid_o && !bus.valu_ready_i;
            held_ops <= {bus.op_a_o, bus.op_b_o, bus.op_c_o};
        end else begin
            stalled <= 1'b0;
        end
    end

    function automatic int words(input logic [2:0] l);
        case (l)
            3'd0:    return (W / 8 > 1) ? W / 8 : 1;
            3'd1:    return (W / 4 > 1) ? W / 4 : 1;
            3'd2:    return (W / 2 > 1) ? W / 2 : 1;
            3'd3:    return W;
            3'd4:    return 2 * W;
            3'd5:    return 4 * W;
            default: return 8 * W;
        endcase
    endfunction

    task automatic build_expect(input logic [2:0] l, input logic [1:0] n,
                                input logic [4:0] s2, input logic [4:0] s1, input logic [4:0] d);
        logic [31:0] m [0:DEPTH-1];
        logic [31:0] res;
        int a2, a1, ad;
        for (int i = 0; i < DEPTH; i++) m[i] = mem[i];
        for (int i = 0; i < words(l); i++) begin
            a2 = (s2 * W + i) % DEPTH;
            a1 = (s1 * W + i) % DEPTH;
            ad = (d * W + i) % DEPTH;
            exp_acc.push_back('{1'b0, a2, 32'd0});
            mdl_a = m[a2];
            if (n >= 2) begin exp_acc.push_back('{1'b0, a1, 32'd0}); mdl_b = m[a1]; end
            if (n == 3) begin exp_acc.push_back('{1'b0, ad, 32'd0}); mdl_c = m[ad]; end
            res = mdl_a + mdl_b + mdl_c;
            exp_ops.push_back({mdl_a, mdl_b, mdl_c});
            exp_acc.push_back('{1'b1, ad, res});
            m[ad] = res;
        end
    endtask

    task automatic launch(input logic [2:0] l, input logic [1:0] n, input logic [4:0] s2,
                          input logic [4:0] s1, input logic [4:0] d, input logic fl);
        @(posedge clk); #1;
        lmul = l; nr = n; vs2 = s2; vs1 = s1; vd = d; flush = fl; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
    endtask

    task automatic run_instr(input string nm, input logic [2:0] l, input logic [1:0] n,
                             input logic [4:0] s2, input logic [4:0] s1, input logic [4:0] d,
                             input logic fl, input int exp_busy);
        int cyc;
        base = seen_addr.size();
        build_expect(l, n, s2, s1, d);
        launch(l, n, s2, s1, d, fl);
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 3000) begin cyc++; @(negedge clk); end
        chk({nm, "_busy_cycles"}, cyc, exp_busy);
        chk({nm, "_done"}, done, 1);
        chk({nm, "_expect_left"}, exp_acc.size() + exp_ops.size(), 0);
        @(negedge clk);
        chk({nm, "_done_pulse"}, done, 0);
        exp_acc.delete();
        exp_ops.delete();
    endtask

    task automatic try_illegal(input string nm, input logic [2:0] l, input logic [1:0] n,
                               input logic [4:0] s2, input logic [4:0] s1, input logic [4:0] d);
        launch(l, n, s2, s1, d, 1'b0);
        @(negedge clk);
        chk({nm, "_err"}, err, 1);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_req"}, bus.vrf_req_o, 0);
        @(negedge clk);
        chk({nm, "_err_pulse"}, err, 0);
        chk({nm, "_busy_after"}, busy, 0);
    endtask

    task automatic wait_read(input int a, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.vrf_req_o && !bus.vrf_we_o && bus.vrf_addr_o == a) ok = 1'b1;
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctrl"}, {busy, done, err, bus.vrf_req_o, bus.vrf_we_o, bus.valu_valid_o}, 0);
        chk({nm, "_addr"}, bus.vrf_addr_o, 0);
        chk({nm, "_wdata"}, bus.vrf_wdata_o, 0);
        chk({nm, "_ops"}, {bus.op_a_o, bus.op_b_o, bus.op_c_o}, 0);
    endtask

    initial begin
        logic ok;
        mem_init = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        chk_en = 1'b1;

        run_instr("lmul1_r2", 3'd3, 2'd2, 5'd1, 5'd2, 5'd3, 1'b0, 20);
        chk("lmul1_first_read", seen_addr[base], 4);
        chk("lmul1_second_read", seen_addr[base + 1], 8);
        chk("lmul1_first_write", seen_addr[base + 2], 12);
        chk("lmul1_access_count", seen_addr.size() - base, 12);
        chk("lmul1_mem12", mem[12], 32'h000C_000C);
        chk("lmul1_mem15", mem[15], 32'h0012_0012);

        run_instr("lmul2_r3", 3'd4, 2'd3, 5'd2, 5'd4, 5'd6, 1'b0, 48);
        chk("lmul2_access_count", seen_addr.size() - base, 32);
        chk("lmul2_mem24", mem[24], 32'h0030_0030);
        chk("lmul2_mem31", mem[31], 32'h0048_0048);

        run_instr("lmulf2_r1_startflush", 3'd2, 2'd1, 5'd5, 5'd0, 5'd7, 1'b1, 8);
        chk("lmulf2_read0", seen_addr[base], 20);
        chk("lmulf2_write0", seen_addr[base + 1], 28);
        chk("lmulf2_write1", seen_addr[base + 3], 29);
        chk("lmulf2_mem28", mem[28], 32'h004A_004A);

        stall_on = 1'b1;
        run_instr("stall", 3'd3, 2'd2, 5'd1, 5'd2, 5'd3, 1'b0, 23);
        stall_on = 1'b0;
        chk("stall_mem12", mem[12], 32'h002B_002B);

        try_illegal("ill_vlmul7", 3'd7, 2'd2, 5'd1, 5'd2, 5'd3);
        try_illegal("ill_nr0", 3'd3, 2'd0, 5'd1, 5'd2, 5'd3);
        try_illegal("ill_align", 3'd5, 2'd2, 5'd4, 5'd8, 5'd2);

        chk_en = 1'b0;
        launch(3'd3, 2'd2, 5'd1, 5'd2, 5'd3, 1'b0);
        wait_read(10, ok);
        chk("flush_reach_word2", ok, 1);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_cycle_gates", {bus.vrf_req_o, bus.valu_valid_o}, 0);
        @(posedge clk); #1 flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush_idle_no_write_no_done", {busy, done, bus.vrf_req_o}, 0);
        end

        launch(3'd3, 2'd2, 5'd1, 5'd2, 5'd3, 1'b0);
        wait_read(8, ok);
        chk("reset_reach_read2", ok, 1);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        @(posedge clk); #1 rst_n = 1'b1;
        mdl_a = '0; mdl_b = '0; mdl_c = '0;
        chk_en = 1'b1;
        run_instr("restart", 3'd3, 2'd2, 5'd1, 5'd2, 5'd3, 1'b0, 20);
        chk("restart_mem12", mem[12], 32'h000C_000C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
